// File: rtl/button_conditioner_pkg.sv
// Shared ALU-project parameters and button conditioner types.
// Default sizes shared by the ALU front panel and its operand path.
package button_conditioner_pkg;

  localparam int NB_OPERANDO    = 8;
  localparam int NB_OPCODE      = 6;
  localparam int NB_BOTONES_DEF = 4;
  localparam int N_DEBOUNCE_DEF = 2;

  typedef struct packed {
    logic estable;
    logic pulso;
  } canal_out_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter,
// stable level register and registered press pulse.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int N_DEBOUNCE = N_DEBOUNCE_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_boton,
  output logic o_estable,
  output logic o_pulso
);

  localparam int CW = $clog2(N_DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  canal_out_t    st;
  logic          difiere;
  logic          toggle;

  assign difiere = sync2 ^ st.estable;
  assign toggle  = difiere && (cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      st    <= '0;
    end else begin
      sync1    <= i_boton;
      sync2    <= sync1;
      // Only a 0->1 acceptance produces a press strobe.
      st.pulso <= toggle & ~st.estable;
      if (!difiere) begin
        cnt <= '0;
      end else if (toggle) begin
        st.estable <= ~st.estable;
        cnt        <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_estable = st.estable;
  assign o_pulso   = st.pulso;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NB_BOTONES raw push buttons into stable levels
// and one-cycle press strobes for the ALU front panel.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NB_BOTONES = NB_BOTONES_DEF,
  parameter int N_DEBOUNCE = N_DEBOUNCE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NB_BOTONES-1:0] i_botones,
  output logic [NB_BOTONES-1:0] o_estables,
  output logic [NB_BOTONES-1:0] o_pulsos
);

  for (genvar g = 0; g < NB_BOTONES; g++) begin : g_canal
    debounce_channel #(
      .N_DEBOUNCE(N_DEBOUNCE)
    ) u_canal (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_boton  (i_botones[g]),
      .o_estable(o_estables[g]),
      .o_pulso  (o_pulsos[g])
    );
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NB_BOTONES, 4, number of independent button channels.
- N_DEBOUNCE, 2, consecutive synchronized cycles of disagreement required to accept a level change; legal range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, input, 1, single system clock; all state is on its rising edge.
- i_reset, input, 1, synchronous, active-high reset.
- i_botones, input, NB_BOTONES, raw asynchronous buttons; bit 0 = boton_1 … bit 3 = boton_4.
- o_estables, output, NB_BOTONES, debounced button level per channel.
- o_pulsos, output, NB_BOTONES, one-cycle pulse per channel on each accepted press; feeds the top_alu load-operand-A / load-operand-B / load-opcode / execute strobes.

Function
REQ-003 Each channel SHALL pass its raw bit through a 2-flop synchronizer (sync1, then sync2) before any other logic.
REQ-004 Each channel SHALL hold a counter of width $clog2(N_DEBOUNCE+1) and a stable-state register.
REQ-005 When sync2 equals the stable state at a clock edge, the counter SHALL clear to 0.
REQ-006 When sync2 differs from the stable state and the counter is below N_DEBOUNCE-1, the counter SHALL increment.
REQ-007 When sync2 differs from the stable state and the counter equals N_DEBOUNCE-1, the stable state SHALL toggle at that same edge and the counter SHALL clear.
REQ-008 Latency SHALL be fixed: if a raw level change is first captured at edge 0, o_estables SHALL change after edge N_DEBOUNCE+1 (edge 3 for the default).
REQ-009 o_pulsos[i] SHALL be registered and high for exactly one cycle, asserted at the same edge at which o_estables[i] goes 0→1.
REQ-010 A 1→0 stable transition SHALL NOT generate a pulse.
REQ-011 A raw glitch that keeps sync2 differing for fewer than N_DEBOUNCE consecutive edges SHALL leave o_estables and o_pulsos unchanged and the counter cleared.
REQ-012 Holding a button indefinitely SHALL produce exactly one pulse; a new pulse SHALL require a debounced release followed by a debounced press.
REQ-013 Channels SHALL be fully independent, so simultaneous presses on several channels SHALL pulse in the same cycle.
REQ-014 The counter SHALL never exceed N_DEBOUNCE-1; no wrap-around is permitted.

Reset
REQ-015 While i_reset is high at a rising edge, sync1, sync2, counters, o_estables and o_pulsos SHALL all become 0, and this SHALL take priority over any debounce action.
REQ-016 Reset asserted mid-count SHALL discard the partial count, and no pulse SHALL appear in the cycle after reset.
REQ-017 A button held high through reset release SHALL be treated as a new press: pulse at edge N_DEBOUNCE+2 counted from the first non-reset edge.

Structure
REQ-018 One channel SHALL be implemented as sub-module debounce_channel (synchronizer, counter, stable register, pulse register), instantiated NB_BOTONES times with a generate loop.
REQ-019 The default N_DEBOUNCE and NB_BOTONES SHALL live in the shared ALU-project parameter header alongside NB_OPERANDO/NB_OPCODE; the counter width SHALL be derived locally.
REQ-020 There SHALL be no combinational path from i_botones to any output.

Verification (20 ns clock, N_DEBOUNCE=2 unless stated)
REQ-021 Press: after reset, i_botones=4'b0001 held 60 ns (3 captures) -> o_pulsos[0] high exactly one cycle at edge 3 after capture; o_estables[0]=1 until debounced release.
REQ-022 Glitch: i_botones[1] high for 1 cycle -> o_estables=0 and o_pulsos=0 throughout.
REQ-023 Hold and release: i_botones[2] high 40 cycles, then low -> one pulse only; o_estables[2] falls 3 edges after low is captured, with no pulse.
REQ-024 Simultaneous: i_botones=4'b1010 in the same cycle -> o_pulsos=4'b1010 for one cycle, then 4'b0000.
REQ-025 Reset mid-count: i_reset pulsed 1 cycle at count 1 while button 3 is high -> no pulse before edge N_DEBOUNCE+2 after reset, then one pulse.
REQ-026 Full stimulus sequence through top_alu: A = -64 (8'hC0), B = 1, opcode ADD (6'b100000) -> out = 8'hC1; then opcode SUB (6'b100010) -> out = 8'hBF.
